ecc_opseq: RTL and testbench
============================

Name: ecc_opseq

Overview:
- Parametrised successor of the ECDSA r/s/k-inverse sequencer.
- Executes one of four fixed micro-programs. Each step reads two RAM slots into the shared modular ALU, waits for the ALU result and writes it back to RAM.
- Adds over the previous generation:
  - a valid/ready command port;
  - a signature-verification program;
  - zero-result detection;
  - a watchdog timeout;
  - abort;
  - an error code on completion.
- Sits between the ECDSA top controller and the slot RAM / modular ALU.

Parameters:
- WID, 256, operand/result width.
- AWID, 5, RAM address width (must be >= 5).
- TOWID, 16, watchdog counter width.
- TMO, 1000, max cycles waiting for adivld; 0 disables the watchdog.
- ZCHK, 1, 1 = flag a zero final result of the R and S programs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- cmd_vld  in  1  command request.
- cmd_prog  in  2  program: 0=R, 1=S, 2=INV, 3=VER.
- cmd_rdy  out  1  high when idle; a command is accepted on cmd_vld & cmd_rdy.
- abort  in  1  cancel the running program.
- busy  out  1  program in progress.
- step  out  2  current step index within the program.
- ramra  out  AWID  registered RAM read address.
- ramwd  out  WID  registered RAM write data.
- ramwa  out  AWID  registered RAM write address.
- ramwe  out  1  registered RAM write enable.
- aen  out  1  ALU start pulse.
- aop  out  2  ALU op: 00=FA, 01=MUL, 10=INV.
- adi  in  WID  ALU result.
- adivld  in  1  ALU result valid.
- rsidone  out  1  completion pulse.
- rserr  out  2  valid with rsidone: 00 ok, 01 zero result, 10 timeout, 11 aborted.

Behaviour:
- Slot map (fixed):
  - X_KG=15, ZRRAM=18, R_NUM=13, PRKEY=17, HASH=16, K_NUM=11, K_INV=12;
  - S_RP=29, S_RPH=30, S_NUM=14, W=20, U1=21, U2=22, BLNK=31.
- Programs (step: srcA, srcB, op -> dst). For unary INV, srcB = srcA.
  - R: 0: X_KG, ZRRAM, FA -> R_NUM.
  - S: 0: R_NUM, PRKEY, MUL -> S_RP; 1: S_RP, HASH, FA -> S_RPH; 2: S_RPH, K_INV, MUL -> S_NUM.
  - INV: 0: K_NUM, K_NUM, INV -> K_INV.
  - VER: 0: S_NUM, S_NUM, INV -> W; 1: HASH, W, MUL -> U1; 2: R_NUM, W, MUL -> U2.
- FSM states: IDLE, LDA, LDB, WAIT.
  - IDLE: on accept, latch the program, set step=0, go to LDA next cycle.
  - LDA, 1 cycle: ramra <= srcA.
  - LDB, 1 cycle: ramra <= srcB, aen=1 for this cycle only, aop = step op. aop holds through WAIT and is 00 otherwise.
  - WAIT: ramra holds srcB; the watchdog counts from 0 each cycle; adivld is sampled only in WAIT.
  - On adivld in WAIT: next cycle ramwe=1, ramwa=dst, ramwd=adi.
    - Not the last step: step++ and go to LDA in that same next cycle.
    - Last step: rsidone=1 in that cycle with ramwe, then IDLE; cmd_rdy is high that cycle.
- Latency, R program: accept at t0, LDA t1, LDB/aen t2, adivld at t>=3, write + done at t+1.
- Zero check (ZCHK=1, R or S program, final step, adi==0): the write still happens, rserr=01.
- Watchdog (TMO!=0): counter reaches TMO in WAIT without adivld -> next cycle rsidone=1, rserr=10, no write, go to IDLE.
- abort high while busy:
  - next cycle rsidone=1, rserr=11, IDLE; no write for the pending step.
  - Writes already issued stand.
  - abort while idle is ignored.
  - abort and adivld in the same cycle: abort wins, no write.
- While idle: adivld is ignored, aen=0, ramwe=0. cmd_vld while busy is not accepted.
- Defaults: ramra=ZRRAM when idle; ramwa=BLNK when ramwe=0; rserr=00 when rsidone=0.
- Reset (async, any state): IDLE, step=0, ramra=18, ramwa=31, ramwd=0, ramwe=0, aen=0, aop=00, rsidone=0, rserr=00, busy=0, cmd_rdy=1. An in-flight program is lost and no done is issued.

Test Plan:
1. R: cmd_prog=0 at t0, adivld with adi=0x5 at t5 -> ramra 15 at t1, 18 at t2, aen=1 at t2 with aop=00; t6: ramwe=1, ramwa=13, ramwd=0x5, rsidone=1, rserr=00.
2. S, ALU replies 3 cycles after each aen, adi=0x7 -> writes to 29, 30, 14 in order with aop 01/00/01; exactly one rsidone with rserr=00; step reads 0,1,2.
3. VER, final adi=0 -> three writes to 20/21/22, rserr=00 (no zero check on VER). Then R with adi=0 -> write to 13, rserr=01.
4. TMO=8, INV, adivld never asserted -> rsidone with rserr=10 9 cycles after entering WAIT; ramwe stays 0; cmd_rdy returns high.
5. Abort during S step 1 WAIT, adivld in the same cycle -> no write to 30, rsidone with rserr=11. Earlier write to 29 is present. A new cmd_prog=2 is then accepted.
6. rst_n low mid-WAIT, then adivld -> all outputs at reset values, no ramwe, no rsidone.

Source files
------------

// File: rtl/ecc_opseq.sv
// ECDSA micro-program sequencer: walks fixed R/S/INV/VER step tables, feeding two
// RAM slots per step to the modular ALU and writing the result back.
module ecc_opseq #(
  parameter int WID   = 256,
  parameter int AWID  = 5,
  parameter int TOWID = 16,
  parameter int TMO   = 1000,
  parameter int ZCHK  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vld,
  input  logic [1:0]      cmd_prog,
  output logic            cmd_rdy,
  input  logic            abort,
  output logic            busy,
  output logic [1:0]      step,
  output logic [AWID-1:0] ramra,
  output logic [WID-1:0]  ramwd,
  output logic [AWID-1:0] ramwa,
  output logic            ramwe,
  output logic            aen,
  output logic [1:0]      aop,
  input  logic [WID-1:0]  adi,
  input  logic            adivld,
  output logic            rsidone,
  output logic [1:0]      rserr
);

  localparam logic [AWID-1:0] K_NUM = AWID'(11), K_INV = AWID'(12), R_NUM = AWID'(13);
  localparam logic [AWID-1:0] S_NUM = AWID'(14), X_KG  = AWID'(15), HASH  = AWID'(16);
  localparam logic [AWID-1:0] PRKEY = AWID'(17), ZRRAM = AWID'(18), W     = AWID'(20);
  localparam logic [AWID-1:0] U1    = AWID'(21), U2    = AWID'(22), S_RP  = AWID'(29);
  localparam logic [AWID-1:0] S_RPH = AWID'(30), BLNK  = AWID'(31);

  localparam logic [1:0] OP_FA = 2'b00, OP_MUL = 2'b01, OP_INV = 2'b10;
  localparam logic [1:0] E_OK = 2'b00, E_ZERO = 2'b01, E_TOUT = 2'b10, E_ABT = 2'b11;

  localparam bit              WD_EN = (TMO != 0);
  localparam logic [TOWID-1:0] TMO_V = TOWID'(TMO);

  typedef enum logic [1:0] {IDLE, LDA, LDB, WAIT} st_t;

  typedef struct packed {
    logic [AWID-1:0] a;
    logic [AWID-1:0] b;
    logic [AWID-1:0] d;
    logic [1:0]      op;
    logic            last;
  } ustep_t;

  function automatic ustep_t ucode(input logic [1:0] p, input logic [1:0] s);
    ustep_t r;
    r = '{a: BLNK, b: BLNK, d: BLNK, op: OP_FA, last: 1'b1};
    case (p)
      2'd0: r = '{a: X_KG, b: ZRRAM, d: R_NUM, op: OP_FA, last: 1'b1};
      2'd1: case (s)
        2'd0:    r = '{a: R_NUM, b: PRKEY, d: S_RP,  op: OP_MUL, last: 1'b0};
        2'd1:    r = '{a: S_RP,  b: HASH,  d: S_RPH, op: OP_FA,  last: 1'b0};
        default: r = '{a: S_RPH, b: K_INV, d: S_NUM, op: OP_MUL, last: 1'b1};
      endcase
      2'd2: r = '{a: K_NUM, b: K_NUM, d: K_INV, op: OP_INV, last: 1'b1};
      default: case (s)
        2'd0:    r = '{a: S_NUM, b: S_NUM, d: W,  op: OP_INV, last: 1'b0};
        2'd1:    r = '{a: HASH,  b: W,     d: U1, op: OP_MUL, last: 1'b0};
        default: r = '{a: R_NUM, b: W,     d: U2, op: OP_MUL, last: 1'b1};
      endcase
    endcase
    return r;
  endfunction

  st_t              state;
  logic [1:0]       prog;
  logic [AWID-1:0]  dst_q;
  logic             last_q;
  logic [TOWID-1:0] wdog;

  logic [1:0] sel_p, sel_s, ferr;
  ustep_t     u;
  logic       fin, wr;

  // One table lookup serves all states: IDLE looks at the incoming program,
  // WAIT pre-fetches the next step's srcA, LDA the current step.
  always_comb begin
    sel_p = prog;
    sel_s = step;
    if (state == IDLE) begin
      sel_p = cmd_prog;
      sel_s = 2'd0;
    end else if (state == WAIT) begin
      sel_s = step + 2'd1;
    end
    u    = ucode(sel_p, sel_s);
    fin  = 1'b0;
    ferr = E_OK;
    wr   = 1'b0;
    if (state != IDLE && abort) begin
      fin  = 1'b1;
      ferr = E_ABT;
    end else if (state == WAIT) begin
      if (adivld) begin
        wr = 1'b1;
        if (last_q) begin
          fin  = 1'b1;
          ferr = (ZCHK != 0 && !prog[1] && adi == '0) ? E_ZERO : E_OK;
        end
      end else if (WD_EN && wdog == TMO_V) begin
        fin  = 1'b1;
        ferr = E_TOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prog    <= 2'd0;
      step    <= 2'd0;
      dst_q   <= BLNK;
      last_q  <= 1'b0;
      wdog    <= '0;
      ramra   <= ZRRAM;
      ramwa   <= BLNK;
      ramwd   <= '0;
      ramwe   <= 1'b0;
      aen     <= 1'b0;
      aop     <= OP_FA;
      rsidone <= 1'b0;
      rserr   <= E_OK;
      busy    <= 1'b0;
      cmd_rdy <= 1'b1;
    end else begin
      ramwe   <= 1'b0;
      ramwa   <= BLNK;
      aen     <= 1'b0;
      rsidone <= 1'b0;
      rserr   <= E_OK;
      if (wr) begin
        ramwe <= 1'b1;
        ramwa <= dst_q;
        ramwd <= adi;
      end
      if (fin) begin
        state   <= IDLE;
        busy    <= 1'b0;
        cmd_rdy <= 1'b1;
        rsidone <= 1'b1;
        rserr   <= ferr;
        ramra   <= ZRRAM;
        aop     <= OP_FA;
      end else begin
        case (state)
          IDLE: if (cmd_vld) begin
            state   <= LDA;
            prog    <= cmd_prog;
            step    <= 2'd0;
            ramra   <= u.a;
            busy    <= 1'b1;
            cmd_rdy <= 1'b0;
          end
          LDA: begin
            state  <= LDB;
            ramra  <= u.b;
            aen    <= 1'b1;
            aop    <= u.op;
            dst_q  <= u.d;
            last_q <= u.last;
          end
          LDB: begin
            state <= WAIT;
            wdog  <= '0;
          end
          default: if (adivld) begin
            state <= LDA;
            step  <= step + 2'd1;
            ramra <= u.a;
            aop   <= OP_FA;
          end else begin
            wdog <= wdog + TOWID'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecc_opseq.sv
// Directed bench for ecc_opseq: latency, program tables, zero check, watchdog, abort, reset.
module tb_ecc_opseq;
  localparam int WID  = 256;
  localparam int AWID = 5;

  logic            clk = 1'b0, rst_n = 1'b0, cmd_vld = 1'b0, abort = 1'b0, adivld = 1'b0;
  logic [1:0]      cmd_prog = 2'd0;
  logic [WID-1:0]  adi = '0;
  logic            cmd_rdy, busy, ramwe, aen, rsidone;
  logic [1:0]      step, aop, rserr;
  logic [AWID-1:0] ramra, ramwa;
  logic [WID-1:0]  ramwd;

  ecc_opseq #(.WID(WID), .AWID(AWID), .TOWID(16), .TMO(8), .ZCHK(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_prog(cmd_prog), .cmd_rdy(cmd_rdy),
    .abort(abort), .busy(busy), .step(step), .ramra(ramra), .ramwd(ramwd), .ramwa(ramwa),
    .ramwe(ramwe), .aen(aen), .aop(aop), .adi(adi), .adivld(adivld), .rsidone(rsidone),
    .rserr(rserr)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic [AWID-1:0] wa_log [8];
  logic [WID-1:0]  wd_log [8];
  logic [1:0]      aop_log [4];
  logic [1:0]      step_log [4];
  int nw, naen, ndone, done_cyc, aen_cyc;
  logic [1:0] last_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and act as the ALU: reply dly cycles after each aen
  // (dly<=0: never reply); abort together with the reply to aen number abort_k.
  task automatic run(input logic [1:0] prog, input logic [WID-1:0] v0, v1, v2,
                     input int dly, input int abort_k);
    logic [WID-1:0] vals [3];
    int due;
    vals = '{v0, v1, v2};
    nw = 0; naen = 0; ndone = 0; done_cyc = -1; aen_cyc = -1; last_err = 2'b00; due = -1;
    cmd_prog = prog; cmd_vld = 1'b1;
    tick;
    cmd_vld = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      adivld = 1'b0; abort = 1'b0;
      if (ramwe) begin
        if (nw < 8) begin wa_log[nw] = ramwa; wd_log[nw] = ramwd; end
        nw++;
      end
      if (rsidone) begin ndone++; last_err = rserr; done_cyc = cyc; end
      if (aen) begin
        if (naen < 4) begin aop_log[naen] = aop; step_log[naen] = step; end
        aen_cyc = cyc;
        naen++;
        due = (dly > 0) ? cyc + dly : -1;
      end
      if (cyc == due) begin
        adivld = 1'b1;
        adi = vals[(naen - 1) % 3];
        if (abort_k == naen - 1) abort = 1'b1;
      end
      tick;
    end
    adivld = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    total++;
    if ({busy, cmd_rdy, step, ramra, ramwa, ramwe, aen, aop, rsidone, rserr} !==
        {1'b0, 1'b1, 2'd0, 5'd18, 5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00})
      $display("FAIL reset_outputs got busy=%b rdy=%b step=%0d ra=%0d wa=%0d we=%b aen=%b aop=%b done=%b err=%b",
               busy, cmd_rdy, step, ramra, ramwa, ramwe, aen, aop, rsidone, rserr);
    else passed++;
    total++;
    if (ramwd !== '0) $display("FAIL reset_ramwd got %0h want 0", ramwd); else passed++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_idle_ignore;
    abort = 1'b1; adivld = 1'b1; adi = 3;
    tick;
    abort = 1'b0; adivld = 1'b0;
    tick;
    total++;
    if ({rsidone, ramwe, busy, aen, cmd_rdy, ramra} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd18})
      $display("FAIL idle_ignore got done=%b we=%b busy=%b aen=%b rdy=%b ra=%0d",
               rsidone, ramwe, busy, aen, cmd_rdy, ramra);
    else passed++;
  endtask

  task automatic test_r_latency;
    total++;
    if (cmd_rdy !== 1'b1) $display("FAIL r_t0_rdy got %b want 1", cmd_rdy); else passed++;
    cmd_prog = 2'd0; cmd_vld = 1'b1;
    tick;                                   // t1: busy; a VER request now must be refused
    cmd_prog = 2'd3;
    total++;
    if ({ramra, busy, cmd_rdy, aen} !== {5'd15, 1'b1, 1'b0, 1'b0})
      $display("FAIL r_t1_lda got ra=%0d busy=%b rdy=%b aen=%b want 15 1 0 0", ramra, busy, cmd_rdy, aen);
    else passed++;
    tick;                                   // t2
    cmd_vld = 1'b0;
    total++;
    if ({aen, aop, ramra} !== {1'b1, 2'b00, 5'd18})
      $display("FAIL r_t2_ldb got aen=%b aop=%b ra=%0d want 1 00 18", aen, aop, ramra);
    else passed++;
    tick;                                   // t3
    total++;
    if ({aen, ramra, ramwe} !== {1'b0, 5'd18, 1'b0})
      $display("FAIL r_t3_wait got aen=%b ra=%0d we=%b want 0 18 0", aen, ramra, ramwe);
    else passed++;
    tick;                                   // t4
    tick;                                   // t5
    adivld = 1'b1; adi = 5;
    tick;                                   // t6
    adivld = 1'b0;
    total++;
    if ({ramwe, ramwa, rsidone, rserr, cmd_rdy} !== {1'b1, 5'd13, 1'b1, 2'b00, 1'b1})
      $display("FAIL r_t6_done got we=%b wa=%0d done=%b err=%b rdy=%b want 1 13 1 00 1",
               ramwe, ramwa, rsidone, rserr, cmd_rdy);
    else passed++;
    total++;
    if (ramwd !== 256'h5) $display("FAIL r_t6_wd got %0h want 5", ramwd); else passed++;
    tick;                                   // t7
    total++;
    if ({ramwe, ramwa, rsidone, rserr, busy, ramra} !== {1'b0, 5'd31, 1'b0, 2'b00, 1'b0, 5'd18})
      $display("FAIL r_t7_idle got we=%b wa=%0d done=%b err=%b busy=%b ra=%0d want 0 31 0 00 0 18",
               ramwe, ramwa, rsidone, rserr, busy, ramra);
    else passed++;
  endtask

  task automatic test_s_prog;
    run(2'd1, 7, 7, 7, 3, -1);
    total++;
    if ({nw, ndone, last_err} !== {32'd3, 32'd1, 2'b00})
      $display("FAIL s_counts got writes=%0d dones=%0d err=%b want 3 1 00", nw, ndone, last_err);
    else passed++;
    total++;
    if ({wa_log[0], wa_log[1], wa_log[2]} !== {5'd29, 5'd30, 5'd14})
      $display("FAIL s_wa got %0d %0d %0d want 29 30 14", wa_log[0], wa_log[1], wa_log[2]);
    else passed++;
    total++;
    if ({aop_log[0], aop_log[1], aop_log[2], step_log[0], step_log[1], step_log[2]} !==
        {2'b01, 2'b00, 2'b01, 2'd0, 2'd1, 2'd2})
      $display("FAIL s_aop_step got aop %b %b %b step %0d %0d %0d want 01 00 01 / 0 1 2",
               aop_log[0], aop_log[1], aop_log[2], step_log[0], step_log[1], step_log[2]);
    else passed++;
    total++;
    if (wd_log[2] !== 256'h7) $display("FAIL s_wd got %0h want 7", wd_log[2]); else passed++;
  endtask

  task automatic test_ver_zero;
    run(2'd3, 4, 6, 0, 3, -1);
    total++;
    if ({nw, ndone, last_err} !== {32'd3, 32'd1, 2'b00})
      $display("FAIL ver_counts got writes=%0d dones=%0d err=%b want 3 1 00", nw, ndone, last_err);
    else passed++;
    total++;
    if ({wa_log[0], wa_log[1], wa_log[2], aop_log[0], aop_log[1], aop_log[2]} !==
        {5'd20, 5'd21, 5'd22, 2'b10, 2'b01, 2'b01})
      $display("FAIL ver_wa_aop got wa %0d %0d %0d aop %b %b %b want 20 21 22 / 10 01 01",
               wa_log[0], wa_log[1], wa_log[2], aop_log[0], aop_log[1], aop_log[2]);
    else passed++;
    total++;
    if ({wd_log[0], wd_log[2]} !== {256'h4, 256'h0})
      $display("FAIL ver_wd got %0h %0h want 4 0", wd_log[0], wd_log[2]);
    else passed++;
    run(2'd0, 0, 0, 0, 4, -1);
    total++;
    if ({nw, ndone, last_err, wa_log[0]} !== {32'd1, 32'd1, 2'b01, 5'd13})
      $display("FAIL r_zero got writes=%0d dones=%0d err=%b wa=%0d want 1 1 01 13",
               nw, ndone, last_err, wa_log[0]);
    else passed++;
  endtask

  task automatic test_timeout;
    run(2'd2, 1, 1, 1, 0, -1);
    total++;
    if ({nw, ndone, last_err} !== {32'd0, 32'd1, 2'b10})
      $display("FAIL tmo_counts got writes=%0d dones=%0d err=%b want 0 1 10", nw, ndone, last_err);
    else passed++;
    total++;
    if (done_cyc - aen_cyc !== 10)
      $display("FAIL tmo_latency got %0d cycles after aen want 10", done_cyc - aen_cyc);
    else passed++;
    total++;
    if ({cmd_rdy, busy} !== 2'b10) $display("FAIL tmo_idle got rdy=%b busy=%b want 1 0", cmd_rdy, busy);
    else passed++;
  endtask

  task automatic test_abort;
    run(2'd1, 7, 7, 7, 3, 1);
    total++;
    if ({nw, ndone, last_err} !== {32'd1, 32'd1, 2'b11})
      $display("FAIL abort_counts got writes=%0d dones=%0d err=%b want 1 1 11", nw, ndone, last_err);
    else passed++;
    total++;
    if (wa_log[0] !== 5'd29) $display("FAIL abort_first_wa got %0d want 29", wa_log[0]); else passed++;
    run(2'd2, 9, 9, 9, 2, -1);
    total++;
    if ({nw, ndone, last_err, wa_log[0], aop_log[0]} !== {32'd1, 32'd1, 2'b00, 5'd12, 2'b10})
      $display("FAIL after_abort_inv got writes=%0d dones=%0d err=%b wa=%0d aop=%b want 1 1 00 12 10",
               nw, ndone, last_err, wa_log[0], aop_log[0]);
    else passed++;
    total++;
    if (wd_log[0] !== 256'h9) $display("FAIL after_abort_wd got %0h want 9", wd_log[0]); else passed++;
  endtask

  task automatic test_reset_mid;
    cmd_prog = 2'd0; cmd_vld = 1'b1;
    tick;
    cmd_vld = 1'b0;
    tick;
    tick;                                   // in WAIT now
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, cmd_rdy, step, ramra, ramwa, ramwe, aen, aop, rsidone, rserr} !==
        {1'b0, 1'b1, 2'd0, 5'd18, 5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00})
      $display("FAIL midreset_outputs got busy=%b rdy=%b step=%0d ra=%0d wa=%0d we=%b aen=%b aop=%b done=%b err=%b",
               busy, cmd_rdy, step, ramra, ramwa, ramwe, aen, aop, rsidone, rserr);
    else passed++;
    total++;
    if (ramwd !== '0) $display("FAIL midreset_ramwd got %0h want 0", ramwd); else passed++;
    tick;
    rst_n = 1'b1;
    adivld = 1'b1; adi = 5;
    tick;
    adivld = 1'b0;
    total++;
    if ({ramwe, rsidone, busy, cmd_rdy} !== 4'b0001)
      $display("FAIL midreset_after got we=%b done=%b busy=%b rdy=%b want 0 0 0 1", ramwe, rsidone, busy, cmd_rdy);
    else passed++;
    tick;
    total++;
    if ({ramwe, rsidone} !== 2'b00)
      $display("FAIL midreset_late got we=%b done=%b want 0 0", ramwe, rsidone);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_idle_ignore;
    test_r_latency;
    test_s_prog;
    test_ver_zero;
    test_timeout;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout bench did not finish within time limit");
    $fatal(1);
  end

endmodule
